// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule types and constants.
package aes_pkg;

  localparam int AES256_NK        = 8;
  localparam int AES256_NR        = 14;
  localparam int AES256_NUM_WORDS = 4 * (AES256_NR + 1);

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;
  typedef logic [3:0]   round_idx_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } store_state_t;

endpackage

// File: rtl/aes_rk_ram.sv
// Round-key register array: one 128-bit entry per round, written one 32-bit
// lane at a time, with a registered 128-bit read port.
module aes_rk_ram
  import aes_pkg::*;
#(
  parameter int DEPTH  = 15,
  parameter int LANE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          wr_lane_en,
  input  logic [3:0]          wr_addr,
  input  logic [LANE_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [3:0]          rd_addr,
  output logic [4*LANE_W-1:0] rd_data
);

  logic [4*LANE_W-1:0] mem [DEPTH];

  // Lane 0 is the most significant word, so w[4r] lands in bits [127:96].
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_lane_en[l]) begin
        mem[wr_addr][(3-l)*LANE_W +: LANE_W] <= wr_data;
      end
    end
  end

  // Read register holds the last accepted round until the next accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/aes_round_key_store.sv
// Collects the 60 expanded AES-256 key words and serves completed round keys
// by index with a fixed one-cycle read latency.
//
//   state      | meaning
//   -----------+----------------------------------------------
//   ST_EMPTY   | no words stored since reset / clear
//   ST_FILLING | 1..59 words stored, rounds become readable as they complete
//   ST_FULL    | all 60 words stored, further writes ignored
module aes_round_key_store
  import aes_pkg::*;
#(
  parameter  int NUM_WORDS  = AES256_NUM_WORDS,
  parameter  int WORD_W     = 32,
  localparam int NUM_ROUNDS = NUM_WORDS / 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                wr_valid,
  input  logic [WORD_W-1:0]   wr_word,
  output logic                wr_ready,
  input  logic                rd_req,
  input  logic [3:0]          rd_round,
  output logic                rd_valid,
  output logic [4*WORD_W-1:0] rd_key,
  output logic                rd_err,
  output logic [3:0]          rounds_avail,
  output logic                full
);

  localparam logic [5:0] LAST_CNT = 6'(NUM_WORDS);

  store_state_t state_q;
  logic [5:0]   word_cnt;
  logic [5:0]   cnt_inc;
  logic         wr_acc;
  logic         rd_ok;
  logic         rd_acc;
  logic         rd_rej;
  logic [3:0]   wr_lane_en;

  assign full     = (state_q == ST_FULL);
  assign wr_ready = ~full;

  // Clear suppresses both ports; reads are judged against the pre-write count,
  // so a round completing this cycle is not yet readable.
  assign wr_acc     = wr_valid & ~full & ~clear;
  assign rd_ok      = (rd_round < rounds_avail);
  assign rd_acc     = rd_req & ~clear & rd_ok;
  assign rd_rej     = rd_req & ~clear & ~rd_ok;
  assign cnt_inc    = word_cnt + 6'd1;
  assign wr_lane_en = wr_acc ? (4'b0001 << word_cnt[1:0]) : 4'b0000;

  // Fill-state FSM with word counter and registered read status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_EMPTY;
      word_cnt     <= '0;
      rounds_avail <= '0;
      rd_valid     <= 1'b0;
      rd_err       <= 1'b0;
    end else if (clear) begin
      state_q      <= ST_EMPTY;
      word_cnt     <= '0;
      rounds_avail <= '0;
      rd_valid     <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      rd_err   <= rd_rej;
      if (wr_acc) begin
        word_cnt     <= cnt_inc;
        rounds_avail <= cnt_inc[5:2];
        state_q      <= (cnt_inc == LAST_CNT) ? ST_FULL : ST_FILLING;
      end
    end
  end

  aes_rk_ram #(
    .DEPTH  (NUM_ROUNDS),
    .LANE_W (WORD_W)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .wr_lane_en (wr_lane_en),
    .wr_addr    (word_cnt[5:2]),
    .wr_data    (wr_word),
    .rd_en      (rd_acc),
    .rd_addr    (rd_round),
    .rd_data    (rd_key)
  );

endmodule
